pixel_diff_acc_ci: RTL

- Second-generation pixel-difference custom instruction for the OpenRISC CI bus.
- Compares packed pixel words lane-by-lane against a programmable absolute-difference threshold.
- Returns the per-lane mask and hit count, and keeps a saturating running total of differing pixels across calls. This lets software compute frame-change metrics without a reduction loop.
- Pipelined: the compare op is multi-cycle; a second CI id gives control and readback access.

---
 rtl/pixel_diff_acc_pkg.sv | 22 ++
 rtl/pixel_diff_acc_ci_lane.sv | 21 ++
 rtl/pixel_diff_acc_ci.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pixel_diff_acc_pkg.sv
// pixel_diff_acc_pkg: shared FSM states, control opcodes and result field offsets
//   for the pixel_diff_acc_ci custom instruction.
package pixel_diff_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMP_S1,
        CMP_DONE,
        CTRL_DONE
    } state_e;

    localparam logic [1:0] OP_READ_ACC  = 2'd0;
    localparam logic [1:0] OP_CLEAR_ACC = 2'd1;
    localparam logic [1:0] OP_SET_THR   = 2'd2;
    localparam logic [1:0] OP_STATUS    = 2'd3;

    localparam int COUNT_LSB = 0;
    localparam int MASK_LSB  = 8;
    localparam int LANES_LSB = 16;
    localparam int SAT_BIT   = 31;

endpackage

// File: rtl/pixel_diff_acc_ci_lane.sv
// pixel_lane_cmp: one pixel lane, flags |a-b| > thr (unsigned, strict).
//   a, b : pixel values
//   thr  : absolute-difference threshold
//   hit  : 1 when the lane differs by more than thr
module pixel_lane_cmp #(
    parameter int PIXEL_BITS = 8
) (
    input  logic [PIXEL_BITS-1:0] a,
    input  logic [PIXEL_BITS-1:0] b,
    input  logic [PIXEL_BITS-1:0] thr,
    output logic                  hit
);

    logic [PIXEL_BITS:0] diff;

    always_comb begin
        diff = (a > b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
        hit  = diff > {1'b0, thr};
    end

endmodule

// File: rtl/pixel_diff_acc_ci.sv
// pixel_diff_acc_ci: pipelined pixel-difference CI with threshold and saturating total.
//   clock, nReset      : clock, asynchronous active-low reset
//   start, ciN         : CI strobe and selector (customId = compare, customId+1 = control)
//   valueA, valueB     : pixel operands, or control opcode (valueA[1:0]) and data (valueB)
//   done, result       : one-cycle completion pulse and result (zero while done is low)
module pixel_diff_acc_ci
    import pixel_diff_acc_pkg::*;
#(
    parameter logic [7:0] customId   = 8'h00,
    parameter int         PIXEL_BITS = 8,
    parameter int         ACC_BITS   = 24
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int LANES = 32 / PIXEL_BITS;

    state_e                state_q, state_d;
    logic [31:0]           a_q, a_d, b_q, b_d;
    logic [ACC_BITS-1:0]   acc_q, acc_d;
    logic                  sat_q, sat_d;
    logic [PIXEL_BITS-1:0] thr_q, thr_d;
    logic                  done_q, done_d;
    logic [31:0]           result_q, result_d;

    logic [LANES-1:0]      hits;
    logic [7:0]            cnt;
    logic [ACC_BITS:0]     sum;
    logic [7:0]            ctrl_id;

    // lane 0 sits in the most significant bits of each operand
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pixel_lane_cmp #(.PIXEL_BITS(PIXEL_BITS)) u_cmp (
            .a   (a_q[31-i*PIXEL_BITS -: PIXEL_BITS]),
            .b   (b_q[31-i*PIXEL_BITS -: PIXEL_BITS]),
            .thr (thr_q),
            .hit (hits[i])
        );
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < LANES; i++) cnt = cnt + 8'(hits[i]);
    end

    // the hit count of the finishing compare is still held in result_q
    assign sum     = {1'b0, acc_q} + {{(ACC_BITS-7){1'b0}}, result_q[COUNT_LSB +: 8]};
    assign ctrl_id = customId + 8'd1;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        thr_d    = thr_q;
        done_d   = 1'b0;
        result_d = '0;
        unique case (state_q)
            IDLE: begin
                if (start && ciN == customId) begin
                    a_d     = valueA;
                    b_d     = valueB;
                    state_d = CMP_S1;
                end else if (start && ciN == ctrl_id) begin
                    done_d  = 1'b1;
                    state_d = CTRL_DONE;
                    unique case (valueA[1:0])
                        OP_READ_ACC:  result_d = 32'(acc_q);
                        OP_CLEAR_ACC: begin
                            result_d = 32'(acc_q);
                            acc_d    = '0;
                            sat_d    = 1'b0;
                        end
                        OP_SET_THR: begin
                            result_d = 32'(thr_q);
                            thr_d    = valueB[PIXEL_BITS-1:0];
                        end
                        default: result_d = (32'(sat_q) << SAT_BIT) | (32'(LANES) << LANES_LSB) | 32'(PIXEL_BITS);
                    endcase
                end
            end
            CMP_S1: begin
                result_d[COUNT_LSB +: 8]    = cnt;
                result_d[MASK_LSB +: LANES] = hits;
                done_d                      = 1'b1;
                state_d                     = CMP_DONE;
            end
            CMP_DONE: begin
                acc_d   = sum[ACC_BITS] ? '1 : sum[ACC_BITS-1:0];
                sat_d   = sat_q | sum[ACC_BITS];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            thr_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            thr_q    <= thr_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
